// File: rtl/font_arb_pkg.sv
// font_arb_pkg: shared widths, overlay indices and the in-flight tag type
// used by font_rom_arbiter and its picker.
package font_arb_pkg;

    localparam int CODE_W  = 4;   // character selector: BCD 0-9, symbols 10-15
    localparam int ROW_W   = 4;   // glyph row, pixel_y[4:1]
    localparam int GLYPH_W = 8;   // one glyph row, MSB is the leftmost pixel
    localparam int IDX_W   = 3;   // requester index, wide enough for 8 overlays

    // Overlay indices; a lower index wins under fixed priority
    localparam logic [IDX_W-1:0] OVL_FECHA  = 3'd0;
    localparam logic [IDX_W-1:0] OVL_HORA   = 3'd1;
    localparam logic [IDX_W-1:0] OVL_CURSOR = 3'd2;

    // One entry of the tag pipeline that travels alongside the ROM access
    typedef struct packed {
        logic             valid;
        logic [IDX_W-1:0] idx;
    } tag_t;

    // Index following idx, wrapping back to 0 after n-1
    function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] idx, input int n);
        return (int'(idx) + 1 >= n) ? '0 : idx + 1'b1;
    endfunction

endpackage

// File: rtl/font_rom_arbiter_if.sv
// font_rom_arbiter_if: overlay request/return bus plus the font ROM address
// and data lines. The master side is the overlays and the ROM, the slave side
// is the arbiter.
interface font_rom_arbiter_if
    import font_arb_pkg::*;
#(
    parameter int NUM_REQ = 3
) ();

    logic                             video_on;
    logic [NUM_REQ-1:0]               req;
    logic [NUM_REQ-1:0][CODE_W-1:0]   code;
    logic [NUM_REQ-1:0][ROW_W-1:0]    row;
    logic [NUM_REQ-1:0]               gnt;
    logic [CODE_W-1:0]                rom_sel;
    logic [ROW_W-1:0]                 rom_row;
    logic [GLYPH_W-1:0]               rom_data;
    logic [GLYPH_W-1:0]               rdata;
    logic [NUM_REQ-1:0]               rvalid;

    modport master (
        output video_on, req, code, row, rom_data,
        input  gnt, rom_sel, rom_row, rdata, rvalid
    );

    modport slave (
        input  video_on, req, code, row, rom_data,
        output gnt, rom_sel, rom_row, rdata, rvalid
    );

endinterface

// File: rtl/font_arb_pick.sv
// font_arb_pick: combinational picker returning the first set request bit at
// or after ptr (round-robin). With FONT_ARB_FIXED_PRIO_EN defined it becomes
// a fixed-priority encoder where index 0 (OVL_FECHA) always wins.
module font_arb_pick
    import font_arb_pkg::*;
#(
    parameter int NUM_REQ = 3
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] win,
    output logic [IDX_W-1:0]   win_idx,
    output logic               any
);

`ifdef FONT_ARB_FIXED_PRIO_EN
    // No pointer in this build; keep the port for a common instantiation
    logic unused_ptr;
    assign unused_ptr = ^ptr;
`endif

    assign any = |req;

    // Scan candidates in priority order and keep the first requester found
    always_comb begin
        int  cand;
        logic found;
        // NOTE: every output gets a default before the loop so no path leaves it unassigned (no latch).
        win     = '0;
        win_idx = '0;
        found   = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
`ifdef FONT_ARB_FIXED_PRIO_EN
            cand = i;
`else
            cand = (int'(ptr) + i) % NUM_REQ;
`endif
            if (!found && req[cand]) begin
                found     = 1'b1;
                win[cand] = 1'b1;
                win_idx   = IDX_W'(cand);
            end
        end
    end

endmodule

// File: rtl/font_rom_arbiter.sv
// font_rom_arbiter: shares one font ROM among the text overlays. One grant
// per clock, ROM address registered the cycle after the grant, returned row
// delivered ROM_LAT+2 cycles after the grant with a one-hot owner tag.
// Define FONT_ARB_FIXED_PRIO_EN for fixed priority (no round-robin pointer).
module font_rom_arbiter
    import font_arb_pkg::*;
#(
    parameter int NUM_REQ = 3,
    parameter int ROM_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    font_rom_arbiter_if.slave bus
);

    localparam logic [NUM_REQ-1:0] ONE_HOT_LSB = NUM_REQ'(1);

    logic [NUM_REQ-1:0] win;
    logic [IDX_W-1:0]   win_idx;
    logic               any_req;
    logic               grant;
    logic [IDX_W-1:0]   ptr;
    logic [CODE_W-1:0]  win_code;
    logic [ROW_W-1:0]   win_row;
    tag_t               new_tag;
    tag_t [ROM_LAT:0]   tag_pipe;
    tag_t               tail;

    font_arb_pick #(.NUM_REQ(NUM_REQ)) u_pick (
        .req     (bus.req),
        .ptr     (ptr),
        .win     (win),
        .win_idx (win_idx),
        .any     (any_req)
    );

    // Grants only happen in the active display region
    assign grant   = bus.video_on & any_req;
    assign bus.gnt = grant ? win : '0;

    // Route the winner's character code and row toward the ROM address
    always_comb begin
        win_code = '0;
        win_row  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (win[i]) begin
                win_code = bus.code[i];
                win_row  = bus.row[i];
            end
        end
    end

    // ROM address register; holds its last value on idle cycles
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (reset) begin
            bus.rom_sel <= '0;
            bus.rom_row <= '0;
        end else if (grant) begin
            bus.rom_sel <= win_code;
            bus.rom_row <= win_row;
        end
    end

`ifdef FONT_ARB_FIXED_PRIO_EN
    // Fixed priority carries no pointer state
    assign ptr = '0;
`else
    // Advance the round-robin pointer just past each winner
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr <= '0;
        end else if (grant) begin
            ptr <= wrap_inc(win_idx, NUM_REQ);
        end
    end
`endif

    assign new_tag.valid = grant;
    assign new_tag.idx   = win_idx;
    assign tail          = tag_pipe[ROM_LAT];

    // Tag pipeline: the owner index rides along with the ROM access
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: the tag pipeline is reset so requests granted before reset never surface as rvalid.
        if (reset) begin
            tag_pipe <= '0;
        end else begin
            tag_pipe <= {tag_pipe[ROM_LAT-1:0], new_tag};
        end
    end

    // Capture the returned glyph row and flag its owner for one cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.rdata  <= '0;
            bus.rvalid <= '0;
        end else begin
            bus.rvalid <= tail.valid ? (ONE_HOT_LSB << tail.idx) : '0;
            if (tail.valid) begin
                bus.rdata <= bus.rom_data;
            end
        end
    end

endmodule

// File: tb/tb_font_rom_arbiter.sv
// tb_font_rom_arbiter: table-driven grant checks with a scoreboard for the
// returned glyph rows, plus hand sequences for reset and ROM_LAT=3.
`timescale 1ns/1ps
module tb_font_rom_arbiter;
    import font_arb_pkg::*;

    localparam int N = 3;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    font_rom_arbiter_if #(.NUM_REQ(N)) bus  ();
    font_rom_arbiter_if #(.NUM_REQ(N)) bus3 ();

    font_rom_arbiter #(.NUM_REQ(N), .ROM_LAT(1)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    font_rom_arbiter #(.NUM_REQ(N), .ROM_LAT(3)) dut3 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus3)
    );

    // ROM contents model: a bijective scramble of {code, row}
    function automatic logic [7:0] glyph(input logic [3:0] s, input logic [3:0] r);
        logic [7:0] v;
        v = {s, r};
        return (v * 8'd37) ^ 8'hC3;
    endfunction

    // ROM models with 1 and 3 cycles of latency
    always @(posedge clk) bus.rom_data <= glyph(bus.rom_sel, bus.rom_row);

    logic [7:0] r3a, r3b;
    always @(posedge clk) begin
        r3a           <= glyph(bus3.rom_sel, bus3.rom_row);
        r3b           <= r3a;
        bus3.rom_data <= r3b;
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard of expected returns for the ROM_LAT=1 instance
    typedef struct {
        int         due;
        logic [N-1:0] onehot;
        logic [7:0] data;
    } exp_t;
    exp_t sb_q[$];

    always @(negedge clk) begin
        if (sb_q.size() > 0 && sb_q[0].due == cyc) begin
            check("sb_rvalid", bus.rvalid, sb_q[0].onehot);
            check("sb_rdata", bus.rdata, sb_q[0].data);
            void'(sb_q.pop_front());
        end else if (bus.rvalid !== '0) begin
            check("sb_spurious_rvalid", bus.rvalid, '0);
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    typedef struct {
        logic        vid;
        logic [2:0]  req;
        logic [11:0] codes;
        logic [11:0] rows;
        logic [2:0]  gnt;
    } vec_t;

    localparam int NV = 19;
    vec_t vecs [NV];

    logic [3:0] exp_sel, exp_row;
    logic [2:0] eg;
    int w;
    int k;
    logic [2:0] exp_rv;

    initial begin
        // Expected gnt assumes round-robin starting from ptr=0
        vecs[0]  = '{1'b1, 3'b111, 12'h3A7, 12'h1F5, 3'b001};
        vecs[1]  = '{1'b1, 3'b111, 12'h3A7, 12'h1F5, 3'b010};
        vecs[2]  = '{1'b1, 3'b111, 12'h3A7, 12'h1F5, 3'b100};
        vecs[3]  = '{1'b1, 3'b111, 12'h3A7, 12'h1F5, 3'b001};
        vecs[4]  = '{1'b1, 3'b000, 12'h3A7, 12'h1F5, 3'b000};
        vecs[5]  = '{1'b1, 3'b001, 12'h007, 12'h005, 3'b001};
        vecs[6]  = '{1'b1, 3'b000, 12'h007, 12'h005, 3'b000};
        vecs[7]  = '{1'b1, 3'b010, 12'h040, 12'h020, 3'b010};
        vecs[8]  = '{1'b1, 3'b110, 12'hC90, 12'h6E0, 3'b100};
        vecs[9]  = '{1'b1, 3'b110, 12'hC90, 12'h6E0, 3'b010};
        vecs[10] = '{1'b0, 3'b111, 12'h123, 12'h456, 3'b000};
        vecs[11] = '{1'b0, 3'b111, 12'h123, 12'h456, 3'b000};
        vecs[12] = '{1'b1, 3'b011, 12'h8D2, 12'h3B9, 3'b001};
        vecs[13] = '{1'b1, 3'b101, 12'hE5F, 12'h70A, 3'b100};
        vecs[14] = '{1'b1, 3'b100, 12'hE5F, 12'h70A, 3'b100};
        vecs[15] = '{1'b1, 3'b000, 12'h000, 12'h000, 3'b000};
        vecs[16] = '{1'b1, 3'b000, 12'h000, 12'h000, 3'b000};
        vecs[17] = '{1'b1, 3'b000, 12'h000, 12'h000, 3'b000};
        vecs[18] = '{1'b1, 3'b000, 12'h000, 12'h000, 3'b000};

        reset = 1'b1;
        bus.video_on  = 1'b0; bus.req  = '0; bus.code  = '0; bus.row  = '0;
        bus3.video_on = 1'b0; bus3.req = '0; bus3.code = '0; bus3.row = '0;
        exp_sel = '0;
        exp_row = '0;

        // Reset state
        @(negedge clk);
        #1;
        check("reset_gnt", bus.gnt, 3'b000);
        check("reset_rvalid", bus.rvalid, 3'b000);
        check("reset_rdata", bus.rdata, 8'h00);
        check("reset_rom_sel", bus.rom_sel, 4'h0);
        check("reset_rom_row", bus.rom_row, 4'h0);
        reset = 1'b0;

        // Table: grant per cycle, address one cycle later, data via scoreboard
        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            check($sformatf("rom_sel[%0d]", i), bus.rom_sel, exp_sel);
            check($sformatf("rom_row[%0d]", i), bus.rom_row, exp_row);
            bus.video_on = vecs[i].vid;
            bus.req      = vecs[i].req;
            bus.code     = vecs[i].codes;
            bus.row      = vecs[i].rows;
            #1;
            eg = vecs[i].gnt;
`ifdef FONT_ARB_FIXED_PRIO_EN
            eg = vecs[i].vid ? (vecs[i].req & (~vecs[i].req + 3'd1)) : 3'b000;
`endif
            check($sformatf("gnt[%0d]", i), bus.gnt, eg);
            if (eg != 3'b000) begin
                w = 0;
                for (int j = 0; j < N; j++) if (eg[j]) w = j;
                exp_sel = vecs[i].codes[w*4 +: 4];
                exp_row = vecs[i].rows[w*4 +: 4];
                sb_q.push_back('{due: cyc + 3, onehot: eg, data: glyph(exp_sel, exp_row)});
            end
        end

        // Reset one cycle after a grant: that request must never return
        @(negedge clk);
        bus.req  = 3'b010;
        bus.code = 12'h0B0;
        bus.row  = 12'h0C0;
        #1;
        check("pre_reset_gnt", bus.gnt, 3'b010);
        @(negedge clk);
        check("pre_reset_rom_sel", bus.rom_sel, 4'hB);
        bus.req = 3'b000;
        reset   = 1'b1;
        sb_q.delete();
        #1;
        check("in_reset_rom_sel", bus.rom_sel, 4'h0);
        check("in_reset_rom_row", bus.rom_row, 4'h0);
        check("in_reset_rdata", bus.rdata, 8'h00);
        check("in_reset_rvalid", bus.rvalid, 3'b000);
        @(negedge clk);
        reset = 1'b0;
        repeat (5) @(negedge clk);
        check("post_reset_rdata", bus.rdata, 8'h00);

        // Pointer restarts at 0 after reset
        bus.req  = 3'b111;
        bus.code = 12'h9D6;
        bus.row  = 12'h2E1;
        #1;
        check("post_reset_gnt", bus.gnt, 3'b001);
        sb_q.push_back('{due: cyc + 3, onehot: 3'b001, data: glyph(4'h6, 4'h1)});
        @(negedge clk);
        bus.req = 3'b000;

        // ROM_LAT=3: back-to-back grants to 0 then 1
        bus3.video_on = 1'b1;
        bus3.req  = 3'b001;
        bus3.code = 12'h002;
        bus3.row  = 12'h009;
        #1;
        check("lat3_gnt0", bus3.gnt, 3'b001);
        k = cyc;
        @(negedge clk);
        check("lat3_rom_sel", bus3.rom_sel, 4'h2);
        check("lat3_rom_row", bus3.rom_row, 4'h9);
        bus3.req  = 3'b010;
        bus3.code = 12'h0B0;
        bus3.row  = 12'h040;
        #1;
        check("lat3_gnt1", bus3.gnt, 3'b010);
        @(negedge clk);
        bus3.req = 3'b000;
        for (int t = 0; t < 8; t++) begin
            exp_rv = (cyc == k + 5) ? 3'b001 : (cyc == k + 6) ? 3'b010 : 3'b000;
            check($sformatf("lat3_rvalid_c%0d", cyc - k), bus3.rvalid, exp_rv);
            if (exp_rv == 3'b001) check("lat3_rdata0", bus3.rdata, glyph(4'h2, 4'h9));
            if (exp_rv == 3'b010) check("lat3_rdata1", bus3.rdata, glyph(4'hB, 4'h4));
            @(negedge clk);
        end
        check("lat3_rdata_hold", bus3.rdata, glyph(4'hB, 4'h4));

        // Every expected return must have been delivered
        repeat (4) @(negedge clk);
        check("sb_drained", sb_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/font_rom_arbiter.md
# font_rom_arbiter

Shares the single character font ROM among the on-screen text overlays: date digits, time digits and programming-cursor labels. Each overlay issues one request per character row. The arbiter picks one request per clock, drives the ROM address and routes the returned 8-bit row to the winning overlay, tagged by index. It sits between the overlay blocks and `font_rom` in the VGA text path, replacing the per-overlay ROM instances.

## Interface
Parameters:
- `NUM_REQ`, 3: number of requesting overlays (2..8).
- `ROM_LAT`, 1: clock cycles from ROM address to valid `rom_data` (1..3).

Ports:
- `clk`  in  1: pixel-domain clock, the only clock.
- `reset`  in  1: asynchronous, active-high reset.
- `video_on`  in  1: active display region; no new grants while low.
- `req`  in  NUM_REQ: one request bit per overlay, level-held until granted.
- `code`  in  NUM_REQ×4: per-overlay character selector, BCD 0–9 plus 10–15 for symbols.
- `row`  in  NUM_REQ×4: per-overlay glyph row, taken from `pixel_y[4:1]`.
- `gnt`  out  NUM_REQ: one-hot grant, one-cycle pulse.
- `rom_sel`  out  4: character selector to the ROM.
- `rom_row`  out  4: row address to the ROM.
- `rom_data`  in  8: ROM row bits, MSB is the leftmost pixel.
- `rdata`  out  8: returned glyph row.
- `rvalid`  out  NUM_REQ: one-hot, marks which overlay owns `rdata`.

## Operation
- Arbitration runs every cycle in which `video_on`=1 and `req`≠0.
  - The arbiter picks the first set `req` bit at or after round-robin pointer `ptr`.
  - It pulses `gnt` for that bit.
  - It registers that requester's `code` and `row` into `rom_sel` and `rom_row`.
  - It sets `ptr` to winner+1, modulo NUM_REQ.
- `ptr` is unchanged on cycles with no grant.
- A requester drops `req` in the cycle after it sees `gnt`. If `req` stays high, the requester is treated as a new request and competes again.
- The grant index and a valid bit travel down a tag pipeline of depth `ROM_LAT`+1, aligned with `rom_data`.
- At the pipeline tail the arbiter registers `rdata` from `rom_data` and asserts the one-hot `rvalid` for the stored index.
- With no grant, `rom_sel` and `rom_row` hold their last values and a zero-valid tag enters the pipeline.
- `video_on` falling:
  - Grants stop immediately.
  - Tags already in flight still complete and deliver `rdata`.
- Simultaneous `req` from every overlay: served in pointer order, one per cycle. No requester waits more than NUM_REQ cycles.
- `ptr` wraps from NUM_REQ−1 to 0.
- Reset mid-operation clears all in-flight tags. No `rvalid` is produced for requests granted before reset.
- Reset values:
  - `gnt`=0, `rvalid`=0, `rdata`=0.
  - `rom_sel`=0, `rom_row`=0, `ptr`=0.
  - Tag pipeline all invalid.

## Timing
- Cycle 0: `req` sampled, `gnt` asserted combinationally from registered `ptr`.
- Cycle 1: `rom_sel` and `rom_row` registered.
- Cycle 1+`ROM_LAT`: `rom_data` is valid at the ROM output.
- Cycle 2+`ROM_LAT`: `rdata` and `rvalid` registered.
- Request-to-data latency is `ROM_LAT`+2. With the default, `gnt` in cycle 0 gives `rvalid` in cycle 3.
- Throughput is one glyph row per clock, sustained.
- `rvalid` is a single-cycle pulse. `rdata` holds until the next `rvalid`.

## Configuration
- `FONT_ARB_FIXED_PRIO_EN` defined:
  - Fixed priority, lowest index wins.
  - `ptr` is removed, so fairness is not guaranteed.
  - Index 0 is the date overlay, the highest priority.
- Undefined: round-robin as described under Operation.
- Latency, ports and reset behaviour are identical in both builds.

## Structure
- Package `font_arb_pkg`:
  - `CODE_W`=4, `ROW_W`=4, `GLYPH_W`=8.
  - Overlay index constants: `OVL_FECHA`=0, `OVL_HORA`=1, `OVL_CURSOR`=2.
  - Tag struct {valid, idx}.
- One sub-module, `font_arb_pick`: combinational rotate-priority picker (`req`, `ptr` → one-hot winner).
  - Under `FONT_ARB_FIXED_PRIO_EN` it reduces to a fixed-priority encoder.
- `font_rom` remains external; the arbiter does not instantiate it.

## Test plan
- Single requester: `req`=001, `code0`=7, `row0`=5 held one cycle → `gnt`=001 at cycle 0, `rom_sel`=7 and `rom_row`=5 at cycle 1, `rvalid`=001 at cycle 3 with `rdata` equal to the ROM model's value for (7, 5).
- All three requesting continuously from `ptr`=0 → `gnt` sequence 001, 010, 100, 001 … and `rvalid` the same sequence delayed 3 cycles. With `FONT_ARB_FIXED_PRIO_EN` defined → `gnt` is 001 on every cycle.
- `req`=110 with `ptr`=2 → `gnt`=100, then `ptr`=0 and the next grant is 010.
- `video_on` drops one cycle after a grant → no further `gnt`, and the granted request still returns `rvalid` 2 cycles later.
- `reset` asserted 1 cycle after a grant → `rvalid` never asserted for it, and `ptr`=0, `rom_sel`=0, `rdata`=0 immediately after reset.
- `ROM_LAT`=3, back-to-back grants to 0 then 1 → `rvalid` 001 at cycle 5 and 010 at cycle 6, each `rdata` matching its own (code, row).
